vred_stream_unit: RTL and testbench

- Parametrised successor to the fixed 64-bit reduction pipeline in the vALU.
- Reduces a multi-beat vector operand (vs2) to one SEW-wide scalar, seeded with vs1[0].
- Supports all eight integer reduction ops in one unified datapath: sum, and, or, xor, minu, min, maxu, max.
- Adds a valid/ready result handshake with full-pipeline stall, and optional per-element masking.

---
 rtl/vred_stream_unit_if.sv | 30 +++
 rtl/vred_stream_unit.sv | 170 +++++++++++++++++
 tb/tb_vred_stream_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vred_stream_unit_if.sv
// vred_stream_unit_if: beat input stream and result output stream of vred_stream_unit.
interface vred_stream_unit_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_vec0;
    logic [DATA_WIDTH-1:0] in_vec1;
    logic [BE_WIDTH-1:0]   in_mask;
    logic                  in_start;
    logic                  in_end;
    logic [2:0]            in_opSel;
    logic [1:0]            in_sew;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_vec;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [BE_WIDTH-1:0]   out_be;
    modport master (
        output in_valid, in_vec0, in_vec1, in_mask, in_start, in_end, in_opSel, in_sew, in_addr, out_ready,
        input  in_ready, out_valid, out_vec, out_addr, out_be
    );
    modport slave (
        input  in_valid, in_vec0, in_vec1, in_mask, in_start, in_end, in_opSel, in_sew, in_addr, out_ready,
        output in_ready, out_valid, out_vec, out_addr, out_be
    );
endinterface

// File: rtl/vred_stream_unit.sv
// vred_stream_unit: pipelined multi-beat integer vector reduction (sum/and/or/xor/minu/min/maxu/max).
// Define VRED_MASK_EN to gate elements with in_mask; otherwise every element is active.
module vred_stream_unit #(
    parameter int DATA_WIDTH    = 64,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 32,
    parameter bit ENABLE_64_BIT = 1'b0,
    parameter int LVLS          = $clog2(DATA_WIDTH / 8)
) (
    input logic               clk,
    input logic               rst,
    vred_stream_unit_if.slave io
);
    localparam int SW = DATA_WIDTH < 64 ? DATA_WIDTH : 64;
    localparam int NE = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  first;
        logic                  last;
        logic                  bad;
        logic [2:0]            op;
        logic [1:0]            sew;
        logic [ADDR_WIDTH-1:0] addr;
        logic [SW-1:0]         seed;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    // m selects the element bits; signed ops extend the element MSB so one 65-bit compare serves all
    function automatic logic [63:0] elem_op(input logic [63:0] a, b, m, input logic [2:0] op);
        logic [63:0] top;
        logic [64:0] xa, xb;
        logic        lt;
        top = m & ~(m >> 1);
        xa  = (op[2] & op[0] & |(a & top)) ? {1'b1, a | ~m} : {1'b0, a & m};
        xb  = (op[2] & op[0] & |(b & top)) ? {1'b1, b | ~m} : {1'b0, b & m};
        lt  = $signed(xa) < $signed(xb);
        return m & (op == 3'd0 ? a + b : op == 3'd1 ? a & b : op == 3'd2 ? a | b :
                     op == 3'd3 ? a ^ b : (op[1] ^ lt) ? a : b);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lanes(input logic [DATA_WIDTH-1:0] a, b,
                                                    input logic [2:0] op, input logic [1:0] sew);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NE; i++)
            if (sew == 2'd0) r[i*8+:8] = 8'(elem_op(64'(a[i*8+:8]), 64'(b[i*8+:8]), 64'hFF, op));
        for (int i = 0; i < NE / 2; i++)
            if (sew == 2'd1) r[i*16+:16] = 16'(elem_op(64'(a[i*16+:16]), 64'(b[i*16+:16]), 64'hFFFF, op));
        for (int i = 0; i < NE / 4; i++)
            if (sew == 2'd2) r[i*32+:32] = 32'(elem_op(64'(a[i*32+:32]), 64'(b[i*32+:32]), 64'hFFFF_FFFF, op));
        for (int i = 0; i < NE / 8; i++)
            if (sew == 2'd3) r[i*64+:64] = elem_op(a[i*64+:64], b[i*64+:64], '1, op);
        return r;
    endfunction

    function automatic logic [63:0] ident(input logic [2:0] op, input logic [63:0] m);
        return op == 3'd1 || op == 3'd4 ? m : op == 3'd5 ? m >> 1 : op == 3'd7 ? m & ~(m >> 1) : '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] gate(input logic [DATA_WIDTH-1:0] v, input logic [NE-1:0] msk,
                                                   input logic [2:0] op, input logic [1:0] sew);
        logic [DATA_WIDTH-1:0] r;
        r = v;
        for (int i = 0; i < NE; i++)
            if (sew == 2'd0 && !msk[i]) r[i*8+:8] = 8'(ident(op, 64'hFF));
        for (int i = 0; i < NE / 2; i++)
            if (sew == 2'd1 && !msk[i]) r[i*16+:16] = 16'(ident(op, 64'hFFFF));
        for (int i = 0; i < NE / 4; i++)
            if (sew == 2'd2 && !msk[i]) r[i*32+:32] = 32'(ident(op, 64'hFFFF_FFFF));
        for (int i = 0; i < NE / 8; i++)
            if (sew == 2'd3 && !msk[i]) r[i*64+:64] = ident(op, '1);
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] smask(input logic [1:0] sew);
        return ~({DATA_WIDTH{1'b1}} << (8 << sew));
    endfunction

    logic                  r_ov;
    logic [DATA_WIDTH-1:0] r_ovec;
    logic [ADDR_WIDTH-1:0] r_oaddr;
    logic [BE_WIDTH-1:0]   r_obe;
    logic                  r_av, r_alast, r_abad;
    logic [1:0]            r_asew;
    logic [ADDR_WIDTH-1:0] r_aaddr;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  w_en;
    logic [NE-1:0]         w_mask;
    beat_t                 w_s [LVLS+1];
    logic                  w_v [LVLS+1];
    beat_t                 w_t;

`ifdef VRED_MASK_EN
    assign w_mask = io.in_mask;
`else
    assign w_mask = io.in_mask | {NE{1'b1}};
`endif

    assign w_en        = ~(r_ov & ~io.out_ready);
    assign io.in_ready = w_en;
    assign w_v[0]      = io.in_valid;
    assign w_s[0]      = '{first: io.in_start, last: io.in_end, bad: io.in_sew == 2'd3 && !ENABLE_64_BIT,
                           op: io.in_opSel, sew: io.in_sew, addr: io.in_addr, seed: io.in_vec1[SW-1:0],
                           data: gate(io.in_vec0, w_mask, io.in_opSel, io.in_sew)};

    // Each stage folds the upper half onto the lower half until only one SEW element remains.
    for (genvar k = 0; k < LVLS; k++) begin : g_stg
        localparam int W = DATA_WIDTH >> k;
        beat_t r_b;
        logic  r_v;
        beat_t w_n;
        always_comb begin
            w_n      = w_s[k];
            w_n.data = W <= (8 << w_s[k].sew) ? w_s[k].data :
                       lanes(w_s[k].data, w_s[k].data >> (W / 2), w_s[k].op, w_s[k].sew) &
                       ({DATA_WIDTH{1'b1}} >> (DATA_WIDTH - W / 2));
        end
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                r_v <= 1'b0;
                r_b <= '0;
            end else if (w_en) begin
                r_v <= w_v[k];
                r_b <= w_n;
            end
        assign w_s[k+1] = r_b;
        assign w_v[k+1] = r_v;
    end

    assign w_t = w_s[LVLS];

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_av    <= 1'b0;
            r_alast <= 1'b0;
            r_abad  <= 1'b0;
            r_asew  <= '0;
            r_aaddr <= '0;
            r_acc   <= '0;
        end else if (w_en) begin
            r_av <= w_v[LVLS];
            if (w_v[LVLS]) begin
                r_acc   <= lanes(w_t.data, w_t.first ? DATA_WIDTH'(w_t.seed) : r_acc, w_t.op, w_t.sew) & smask(w_t.sew);
                r_alast <= w_t.last;
                r_abad  <= w_t.bad;
                r_asew  <= w_t.sew;
                r_aaddr <= w_t.addr;
            end
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_ov    <= 1'b0;
            r_ovec  <= '0;
            r_oaddr <= '0;
            r_obe   <= '0;
        end else if (w_en) begin
            r_ov <= r_av & r_alast;
            if (r_av & r_alast) begin
                r_ovec  <= r_abad ? '0 : r_acc;
                r_oaddr <= r_aaddr;
                r_obe   <= r_abad ? '0 : BE_WIDTH'((1 << (1 << r_asew)) - 1);
            end
        end

    assign io.out_valid = r_ov;
    assign io.out_vec   = r_ovec;
    assign io.out_addr  = r_oaddr;
    assign io.out_be    = r_obe;
endmodule

// File: tb/tb_vred_stream_unit.sv
// tb_vred_stream_unit: directed vectors; expected results queued at issue, checked by an output monitor.
`timescale 1ns/1ps
module tb_vred_stream_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vred_stream_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) io ();
    vred_stream_unit #(.DATA_WIDTH(64), .BE_WIDTH(8), .ADDR_WIDTH(32), .ENABLE_64_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .io(io)
    );

    typedef struct {
        logic [63:0] vec;
        logic [7:0]  be;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst && io.out_valid && io.out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got out_vec 0x%0h, want no result", io.out_vec);
            end else begin
                e = sb.pop_front();
                chk("out_vec", io.out_vec, e.vec);
                chk("out_be", 64'(io.out_be), 64'(e.be));
                chk("out_addr", 64'(io.out_addr), 64'(e.addr));
            end
        end
    end

    task automatic expect_res(input logic [63:0] v, input logic [7:0] be, input logic [31:0] a);
        exp_t x;
        x.vec  = v;
        x.be   = be;
        x.addr = a;
        sb.push_back(x);
    endtask

    task automatic send(input logic [63:0] v0, v1, input logic [7:0] m, input logic s, en,
                        input logic [2:0] op, input logic [1:0] sew, input logic [31:0] a, output int c0);
        int g = 0;
        @(negedge clk);
        io.in_vec0  = v0;
        io.in_vec1  = v1;
        io.in_mask  = m;
        io.in_start = s;
        io.in_end   = en;
        io.in_opSel = op;
        io.in_sew   = sew;
        io.in_addr  = a;
        io.in_valid = 1'b1;
        #1;
        while (!io.in_ready && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (!io.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready 0, want 1");
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        io.in_valid = 1'b0;
    endtask

    task automatic one(input logic [63:0] v0, seed, input logic [2:0] op, input logic [1:0] sew,
                       input logic [31:0] a, input logic [63:0] want, input logic [7:0] be);
        int c0;
        expect_res(want, be, a);
        send(v0, seed, 8'hFF, 1'b1, 1'b1, op, sew, a, c0);
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int g;
        io.in_valid  = 1'b0;
        io.in_vec0   = '0;
        io.in_vec1   = '0;
        io.in_mask   = '0;
        io.in_start  = 1'b0;
        io.in_end    = 1'b0;
        io.in_opSel  = '0;
        io.in_sew    = '0;
        io.in_addr   = '0;
        io.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(io.out_valid), 64'd0);
        chk("rst_in_ready", 64'(io.in_ready), 64'd1);
        chk("rst_out_vec", io.out_vec, 64'd0);
        chk("rst_out_be", 64'(io.out_be), 64'd0);
        chk("rst_out_addr", 64'(io.out_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        expect_res(64'h34, 8'h01, 32'h100);
        send(64'h0807060504030201, 64'h10, 8'hFF, 1'b1, 1'b1, 3'd0, 2'd0, 32'h100, c0);
        g = 0;
        while (!io.out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("latency_edges", 64'(cyc - c0), 64'd4);
        drain();

        expect_res(64'h35, 8'h01, 32'h104);
        send(64'h01, 64'hAA, 8'hFF, 1'b0, 1'b1, 3'd0, 2'd0, 32'h104, c0);

        expect_res(64'h8000_0000, 8'h0F, 32'h200);
        send(64'h80000000_00000001, 64'h9, 8'hFF, 1'b1, 1'b0, 3'd6, 2'd2, 32'h0, c0);
        send(64'h00000003_00000007, 64'h0, 8'hFF, 1'b0, 1'b0, 3'd6, 2'd2, 32'h0, c0);
        send(64'h00000002_00000005, 64'h0, 8'hFF, 1'b0, 1'b1, 3'd6, 2'd2, 32'h200, c0);
        expect_res(64'h9, 8'h0F, 32'h204);
        send(64'h80000000_00000001, 64'h9, 8'hFF, 1'b1, 1'b0, 3'd7, 2'd2, 32'h0, c0);
        send(64'h00000003_00000007, 64'h0, 8'hFF, 1'b0, 1'b0, 3'd7, 2'd2, 32'h0, c0);
        send(64'h00000002_00000005, 64'h0, 8'hFF, 1'b0, 1'b1, 3'd7, 2'd2, 32'h204, c0);

        one(64'hFFFF_FFFF_FFFF_FFFF, 64'h4, 3'd0, 2'd1, 32'h300, 64'h0, 8'h03);
        one(64'h0102040810204080, 64'h0, 3'd3, 2'd0, 32'h400, 64'hFF, 8'h01);
        one(64'h0001_0010_0100_1000, 64'h8000, 3'd2, 2'd1, 32'h404, 64'h9111, 8'h03);
        one(64'hFFFFFFFF_00000005, 64'h7, 3'd4, 2'd2, 32'h408, 64'h5, 8'h0F);
        one(64'h7F80010203040506, 64'h0, 3'd5, 2'd0, 32'h40C, 64'h80, 8'h01);
        one(64'hF0FFFFFFFFFFFF3F, 64'hFF, 3'd1, 2'd0, 32'h410, 64'h30, 8'h01);
        one(64'h8000_FFFF_0003_7FFE, 64'hFFFE, 3'd7, 2'd1, 32'h414, 64'h7FFE, 8'h03);
        one(64'h80000000_7FFFFFFF, 64'h0, 3'd5, 2'd2, 32'h418, 64'h8000_0000, 8'h0F);

        expect_res(64'h5, 8'h01, 32'h500);
        send(64'h05, 64'h01, 8'hFF, 1'b1, 1'b0, 3'd0, 2'd0, 32'h4FF, c0);
        send(64'h02, 64'h03, 8'hFF, 1'b1, 1'b1, 3'd0, 2'd0, 32'h500, c0);

        one(64'h1234, 64'h1, 3'd0, 2'd3, 32'h600, 64'h0, 8'h00);

`ifdef VRED_MASK_EN
        expect_res(64'hFF, 8'h01, 32'h900);
        send(64'h00FFFFFFFFFFFFFF, 64'hFF, 8'h7F, 1'b1, 1'b1, 3'd1, 2'd0, 32'h900, c0);
        expect_res(64'h5A, 8'h01, 32'h904);
        send(64'h00FFFFFFFFFFFFFF, 64'h5A, 8'h00, 1'b1, 1'b1, 3'd1, 2'd0, 32'h904, c0);
`else
        expect_res(64'h00, 8'h01, 32'h900);
        send(64'h00FFFFFFFFFFFFFF, 64'hFF, 8'h7F, 1'b1, 1'b1, 3'd1, 2'd0, 32'h900, c0);
        expect_res(64'h00, 8'h01, 32'h904);
        send(64'h00FFFFFFFFFFFFFF, 64'h5A, 8'h00, 1'b1, 1'b1, 3'd1, 2'd0, 32'h904, c0);
`endif
        drain();

        io.out_ready = 1'b0;
        expect_res(64'h08, 8'h01, 32'h700);
        send(64'h0101010101010101, 64'h0, 8'hFF, 1'b1, 1'b1, 3'd0, 2'd0, 32'h700, c0);
        expect_res(64'hF1, 8'h01, 32'h704);
        send(64'hFF, 64'h0F, 8'hFF, 1'b1, 1'b0, 3'd3, 2'd0, 32'h0, c0);
        send(64'h01, 64'h0, 8'hFF, 1'b0, 1'b1, 3'd3, 2'd0, 32'h704, c0);
        g = 0;
        while (!io.out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("stall_out_valid", 64'(io.out_valid), 64'd1);
            chk("stall_in_ready", 64'(io.in_ready), 64'd0);
            chk("stall_out_vec", io.out_vec, 64'h08);
        end
        io.out_ready = 1'b1;
        drain();

        send(64'h11, 64'h22, 8'hFF, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, c0);
        send(64'h33, 64'h0, 8'hFF, 1'b0, 1'b1, 3'd0, 2'd0, 32'h7FC, c0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(io.out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(io.in_ready), 64'd1);
        chk("rst_mid_out_vec", io.out_vec, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        one(64'h03, 64'h02, 3'd0, 2'd0, 32'h800, 64'h05, 8'h01);
        drain();

        repeat (10) @(negedge clk);
        #1;
        chk("final_out_valid", 64'(io.out_valid), 64'd0);
        chk("final_queue_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
